// File: rtl/usr_pkg.sv
// ============================================================================
// Module  : usr_pkg
// Purpose : Shared command encodings and FSM state type for usr_shift_ctrl.
// Rev     : 1.0
// ============================================================================
`default_nettype none

package usr_pkg;

  localparam logic [1:0] SEL_HOLD = 2'b00;
  localparam logic [1:0] SEL_SHR  = 2'b01;
  localparam logic [1:0] SEL_SHL  = 2'b10;
  localparam logic [1:0] SEL_LOAD = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_LOAD  = 2'b01,
    ST_SHIFT = 2'b10,
    ST_DONE  = 2'b11
  } state_e;

  // Shift command for the latched direction (0 = right, 1 = left).
  function automatic logic [1:0] shift_sel(input logic dir);
    return dir ? SEL_SHL : SEL_SHR;
  endfunction

endpackage

`default_nettype wire

// File: rtl/univ_shift_reg.sv
// ============================================================================
// Module  : univ_shift_reg
// Purpose : WIDTH-bit universal shift register (hold / SHR / SHL / load).
// Rev     : 1.0
// ============================================================================
`default_nettype none

module univ_shift_reg
  import usr_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       sel,
  input  logic [WIDTH-1:0] din,
  input  logic             ser_in,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  always_comb begin
    q_d = q_q;
    unique case (sel)
      SEL_SHR:  q_d = {ser_in, q_q[WIDTH-1:1]};
      SEL_SHL:  q_d = {q_q[WIDTH-2:0], ser_in};
      SEL_LOAD: q_d = din;
      default:  q_d = q_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

`default_nettype wire

// File: rtl/usr_shift_ctrl.sv
// ============================================================================
// Module  : usr_shift_ctrl
// Purpose : Load-and-shift job sequencer driving a universal shift register.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module usr_shift_ctrl
  import usr_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             dir,
  input  logic [CNT_W-1:0] count,
  input  logic [WIDTH-1:0] din,
  input  logic             ser_in,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [1:0]       sel,
  output logic [WIDTH-1:0] q,
  output logic             ser_out
);

  state_e           state_q, state_d;
  logic             dir_q, dir_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] din_q, din_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      dir_q   <= 1'b0;
      cnt_q   <= '0;
      rem_q   <= '0;
      din_q   <= '0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      din_q   <= din_d;
    end
  end

  // Job fields are captured only on acceptance, so input changes while busy are inert.
  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    din_d   = din_q;
    sel     = SEL_HOLD;
    ready   = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        ready = 1'b1;
        if (start) begin
          dir_d   = dir;
          cnt_d   = count;
          din_d   = din;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        sel     = SEL_LOAD;
        busy    = 1'b1;
        rem_d   = cnt_q;
        state_d = (cnt_q != '0) ? ST_SHIFT : ST_DONE;
      end
      ST_SHIFT: begin
        sel   = shift_sel(dir_q);
        busy  = 1'b1;
        rem_d = rem_q - 1'b1;
        if (rem_q == CNT_W'(1)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  univ_shift_reg #(
    .WIDTH (WIDTH)
  ) u_reg (
    .clk    (clk),
    .rst_n  (rst_n),
    .sel    (sel),
    .din    (din_q),
    .ser_in (ser_in),
    .q      (q)
  );

  assign ser_out = dir_q ? q[WIDTH-1] : q[0];

endmodule

`default_nettype wire
